// File: rtl/centroid_pkg.sv
// Shared widths, FSM encodings and result record for the multi-channel centroid tracker.
package centroid_pkg;
    localparam int DEF_X_W     = 11;
    localparam int DEF_Y_W     = 10;
    localparam int DEF_COUNT_W = 20;
    localparam int DEF_CH_W    = 2;
    localparam int SUM_X_W     = DEF_X_W + DEF_COUNT_W;
    localparam int SUM_Y_W     = DEF_Y_W + DEF_COUNT_W;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_DIV_X = 3'd2;
    localparam state_t ST_DIV_Y = 3'd3;
    localparam state_t ST_EMIT  = 3'd4;

    // One emitted result at the default interface widths.
    typedef struct packed {
        logic [DEF_CH_W-1:0]    ch;
        logic [DEF_X_W-1:0]     x;
        logic [DEF_Y_W-1:0]     y;
        logic [DEF_COUNT_W-1:0] count;
        logic                   found;
        logic                   sat;
    } result_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/centroid_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, done DIVIDEND_W+1 cycles after start.
module centroid_divider #(
    parameter int DIVIDEND_W = 31,
    parameter int DIVISOR_W  = 20,
    parameter int QUOTIENT_W = DIVIDEND_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [QUOTIENT_W-1:0] quotient,
    output logic                  done
);
    localparam int STEP_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] dq;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  dvs;
    logic [STEP_W-1:0]     steps;
    logic                  busy;
    logic [DIVISOR_W:0]    trial;
    logic                  fits;

    always_comb begin
        trial = {rem, dq[DIVIDEND_W-1]};
        fits  = trial >= {1'b0, dvs};
    end

    // dq shifts the dividend out at the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq    <= '0;
            rem   <= '0;
            dvs   <= '0;
            steps <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            dq    <= dividend;
            rem   <= '0;
            dvs   <= divisor;
            steps <= STEP_W'(DIVIDEND_W);
            busy  <= 1'b1;
        end else if (busy) begin
            if (steps != '0) begin
                rem   <= fits ? DIVISOR_W'(trial - {1'b0, dvs}) : trial[DIVISOR_W-1:0];
                dq    <= {dq[DIVIDEND_W-2:0], fits};
                steps <= steps - 1'b1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done     = busy && (steps == '0);
    assign quotient = dq[QUOTIENT_W-1:0];
endmodule

// File: rtl/centroid_tracker.sv
// Per-channel centre-of-mass tracker: live accumulators, frame-end shadow bank,
// one shared divider and a valid/ready result stream in ascending channel order.
module centroid_tracker
    import centroid_pkg::*;
#(
    parameter int X_W        = 11,
    parameter int Y_W        = 10,
    parameter int COUNT_W    = 20,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int MIN_PIXELS = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    input  logic [CH_W-1:0]    ch_in,
    input  logic               valid_in,
    input  logic               tabulate_in,
    input  logic               ready_in,
    output logic               valid_out,
    output logic [CH_W-1:0]    ch_out,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COUNT_W-1:0] count_out,
    output logic               found_out,
    output logic               sat_out,
    output logic               frame_drop_out
);
    localparam int SX_W    = X_W + COUNT_W;
    localparam int SY_W    = Y_W + COUNT_W;
    localparam int DIV_W   = max_w(SX_W, SY_W);
    localparam int COORD_W = max_w(X_W, Y_W);
    localparam logic [COUNT_W-1:0] MIN_CNT = COUNT_W'(MIN_PIXELS);

    function automatic logic count_full(input logic [COUNT_W-1:0] c);
        return &c;
    endfunction

    logic [SX_W-1:0]    live_sx    [NUM_CH];
    logic [SY_W-1:0]    live_sy    [NUM_CH];
    logic [COUNT_W-1:0] live_cnt   [NUM_CH];
    logic [NUM_CH-1:0]  live_sat;
    logic [SX_W-1:0]    shadow_sx  [NUM_CH];
    logic [SY_W-1:0]    shadow_sy  [NUM_CH];
    logic [COUNT_W-1:0] shadow_cnt [NUM_CH];
    logic [NUM_CH-1:0]  shadow_sat;

    state_t            state;
    logic [CH_W-1:0]   idx;
    logic              pix_hit;
    logic              blob_found;
    logic              div_start;
    logic [DIV_W-1:0]  div_dividend;
    logic [COORD_W-1:0] div_quot;
    logic              div_done;

    assign pix_hit    = valid_in && (int'(ch_in) < NUM_CH);
    assign blob_found = shadow_cnt[idx] >= MIN_CNT;

    // A pixel coincident with tabulate becomes the first sample of the freshly cleared bank.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                live_sx[c]  <= '0;
                live_sy[c]  <= '0;
                live_cnt[c] <= '0;
            end
            live_sat <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (pix_hit && int'(ch_in) == c) begin
                    if (tabulate_in) begin
                        live_sx[c]  <= SX_W'(x_in);
                        live_sy[c]  <= SY_W'(y_in);
                        live_cnt[c] <= COUNT_W'(1);
                        live_sat[c] <= 1'b0;
                    end else if (count_full(live_cnt[c])) begin
                        live_sat[c] <= 1'b1;
                    end else begin
                        live_sx[c]  <= live_sx[c] + SX_W'(x_in);
                        live_sy[c]  <= live_sy[c] + SY_W'(y_in);
                        live_cnt[c] <= live_cnt[c] + 1'b1;
                    end
                end else if (tabulate_in) begin
                    live_sx[c]  <= '0;
                    live_sy[c]  <= '0;
                    live_cnt[c] <= '0;
                    live_sat[c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        div_start    = 1'b0;
        div_dividend = '0;
        if (state == ST_LOAD && blob_found) begin
            div_start    = 1'b1;
            div_dividend = DIV_W'(shadow_sx[idx]);
        end else if (state == ST_DIV_X && div_done) begin
            div_start    = 1'b1;
            div_dividend = DIV_W'(shadow_sy[idx]);
        end
    end

    centroid_divider #(
        .DIVIDEND_W(DIV_W),
        .DIVISOR_W (COUNT_W),
        .QUOTIENT_W(COORD_W)
    ) u_div (
        .clk     (clk_in),
        .rst     (rst_in),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (shadow_cnt[idx]),
        .quotient(div_quot),
        .done    (div_done)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_sx[c]  <= '0;
                shadow_sy[c]  <= '0;
                shadow_cnt[c] <= '0;
            end
            shadow_sat     <= '0;
            state          <= ST_IDLE;
            idx            <= '0;
            x_out          <= '0;
            y_out          <= '0;
            count_out      <= '0;
            found_out      <= 1'b0;
            sat_out        <= 1'b0;
            frame_drop_out <= 1'b0;
        end else begin
            frame_drop_out <= tabulate_in && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (tabulate_in) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            shadow_sx[c]  <= live_sx[c];
                            shadow_sy[c]  <= live_sy[c];
                            shadow_cnt[c] <= live_cnt[c];
                        end
                        shadow_sat <= live_sat;
                        idx        <= '0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_out <= shadow_cnt[idx];
                    sat_out   <= shadow_sat[idx];
                    found_out <= blob_found;
                    if (blob_found) begin
                        state <= ST_DIV_X;
                    end else begin
                        x_out <= '0;
                        y_out <= '0;
                        state <= ST_EMIT;
                    end
                end
                ST_DIV_X: begin
                    if (div_done) begin
                        x_out <= div_quot[X_W-1:0];
                        state <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done) begin
                        y_out <= div_quot[Y_W-1:0];
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (ready_in) begin
                        if (idx == CH_W'(NUM_CH - 1)) begin
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign valid_out = (state == ST_EMIT);
    assign ch_out    = idx;
endmodule

// File: tb/tb_centroid_tracker.sv
// Scoreboard bench for centroid_tracker: default instance plus a narrow-counter instance.
module tb_centroid_tracker;
    import centroid_pkg::*;

    localparam int LAT_FOUND = 1 + 2 * (max_w(SUM_X_W, SUM_Y_W) + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] x;
    logic [9:0]  y;
    logic [1:0]  ch;
    logic        valid, tab, ready, b_valid, b_tab;

    logic        a_valid, a_found, a_sat, a_drop;
    logic [1:0]  a_ch;
    logic [10:0] a_x;
    logic [9:0]  a_y;
    logic [19:0] a_count;
    logic        b_valid_o, b_found, b_sat, b_drop;
    logic [1:0]  b_ch;
    logic [10:0] b_x;
    logic [9:0]  b_y;
    logic [3:0]  b_count;

    int checks = 0;
    int errors = 0;
    longint m_sx[4];
    longint m_sy[4];
    int m_cnt[4];
    bit m_sat[4];
    int cnt_max;
    int min_px;
    result_t exp_q[$];

    always #5 clk = ~clk;

    centroid_tracker dut_a (
        .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .ch_in(ch),
        .valid_in(valid), .tabulate_in(tab), .ready_in(ready),
        .valid_out(a_valid), .ch_out(a_ch), .x_out(a_x), .y_out(a_y),
        .count_out(a_count), .found_out(a_found), .sat_out(a_sat), .frame_drop_out(a_drop)
    );

    centroid_tracker #(.COUNT_W(4), .MIN_PIXELS(1)) dut_b (
        .clk_in(clk), .rst_in(rst), .x_in(x), .y_in(y), .ch_in(ch),
        .valid_in(b_valid), .tabulate_in(b_tab), .ready_in(ready),
        .valid_out(b_valid_o), .ch_out(b_ch), .x_out(b_x), .y_out(b_y),
        .count_out(b_count), .found_out(b_found), .sat_out(b_sat), .frame_drop_out(b_drop)
    );

    function automatic string fmt(input result_t r);
        return $sformatf("ch=%0d x=%0d y=%0d count=%0d found=%0b sat=%0b",
                         r.ch, r.x, r.y, r.count, r.found, r.sat);
    endfunction

    function automatic result_t got_a();
        return {a_ch, a_x, a_y, a_count, a_found, a_sat};
    endfunction

    function automatic result_t got_b();
        return {b_ch, b_x, b_y, 16'd0, b_count, b_found, b_sat};
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 4; c++) begin
            m_sx[c] = 0; m_sy[c] = 0; m_cnt[c] = 0; m_sat[c] = 1'b0;
        end
    endfunction

    function automatic void model_pixel(input int c, input int px, input int py);
        if (m_cnt[c] == cnt_max) begin
            m_sat[c] = 1'b1;
        end else begin
            m_cnt[c]++;
            m_sx[c] += px;
            m_sy[c] += py;
        end
    endfunction

    function automatic void model_push();
        for (int c = 0; c < 4; c++) begin
            result_t r;
            r.ch    = 2'(c);
            r.count = 20'(m_cnt[c]);
            r.sat   = m_sat[c];
            r.found = (m_cnt[c] >= min_px);
            r.x     = r.found ? 11'(m_sx[c] / m_cnt[c]) : 11'd0;
            r.y     = r.found ? 10'(m_sy[c] / m_cnt[c]) : 10'd0;
            exp_q.push_back(r);
        end
    endfunction

    task automatic send_pixel(input bit to_b, input int c, input int px, input int py);
        x = 11'(px); y = 10'(py); ch = 2'(c);
        if (to_b) b_valid = 1'b1; else valid = 1'b1;
        model_pixel(c, px, py);
        @(negedge clk);
        valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic pulse_tab(input bit to_b, input bit drop, input bit with_px,
                             input int c, input int px, input int py);
        if (to_b) b_tab = 1'b1; else tab = 1'b1;
        if (!drop) model_push();
        model_clear();
        if (with_px) begin
            x = 11'(px); y = 10'(py); ch = 2'(c); valid = 1'b1;
            model_pixel(c, px, py);
        end
        @(negedge clk);
        tab = 1'b0; b_tab = 1'b0; valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 0; tab = 0; ready = 0; b_valid = 0; b_tab = 0;
        x = '0; y = '0; ch = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_valid, a_ch, a_x, a_y, a_count, a_found, a_sat, a_drop} !== '0) begin
            errors++; $display("FAIL reset_a: outputs=%h, required 0",
                {a_valid, a_ch, a_x, a_y, a_count, a_found, a_sat, a_drop});
        end
        checks++;
        if ({b_valid_o, b_ch, b_x, b_y, b_count, b_found, b_sat, b_drop} !== '0) begin
            errors++; $display("FAIL reset_b: outputs=%h, required 0",
                {b_valid_o, b_ch, b_x, b_y, b_count, b_found, b_sat, b_drop});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        result_t e;
        ready = 1'b1;
        for (int k = 0; k < 16; k++) send_pixel(0, 0, 100 + k, 50);
        pulse_tab(0, 0, 1, 3, 5, 6);
        checks++;
        if (a_drop !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b, required 0", a_drop); end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!a_valid && n < 300) begin @(negedge clk); n++; end
            if (k == 0) begin
                checks++;
                if (n != LAT_FOUND) begin errors++; $display("FAIL basic_latency: got %0d, required %0d", n, LAT_FOUND); end
            end
            e = exp_q.pop_front();
            checks++;
            if (!a_valid || got_a() !== e) begin
                errors++; $display("FAIL basic_result: valid=%b %s, required %s", a_valid, fmt(got_a()), fmt(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_pressure();
        int n;
        result_t e;
        ready = 1'b0;
        for (int k = 0; k < 16; k++) send_pixel(0, 0, $urandom_range(0, 2047), $urandom_range(0, 1023));
        pulse_tab(0, 0, 0, 0, 0, 0);
        n = 0;
        while (!a_valid && n < 300) begin @(negedge clk); n++; end
        e = exp_q.pop_front();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (!a_valid || got_a() !== e) begin
                errors++; $display("FAIL bp_hold cycle %0d: valid=%b %s, required valid=1 %s", k, a_valid, fmt(got_a()), fmt(e));
            end
            @(negedge clk);
        end
        ready = 1'b1;
        @(negedge clk);
        for (int k = 1; k < 4; k++) begin
            n = 0;
            while (!a_valid && n < 300) begin @(negedge clk); n++; end
            e = exp_q.pop_front();
            checks++;
            if (!a_valid || got_a() !== e) begin
                errors++; $display("FAIL bp_result: valid=%b %s, required %s", a_valid, fmt(got_a()), fmt(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_frame_drop();
        int n;
        result_t e;
        ready = 1'b1;
        for (int k = 0; k < 20; k++) send_pixel(0, 0, $urandom_range(0, 2047), $urandom_range(0, 1023));
        for (int k = 0; k < 17; k++) send_pixel(0, 3, $urandom_range(0, 2047), $urandom_range(0, 1023));
        pulse_tab(0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        for (int k = 0; k < 3; k++) send_pixel(0, 2, 1, 1);
        pulse_tab(0, 1, 0, 0, 0, 0);
        checks++;
        if (a_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b, required 1", a_drop); end
        @(negedge clk);
        checks++;
        if (a_drop !== 1'b0) begin errors++; $display("FAIL drop_width: got %b, required 0", a_drop); end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!a_valid && n < 300) begin @(negedge clk); n++; end
            e = exp_q.pop_front();
            checks++;
            if (!a_valid || got_a() !== e) begin
                errors++; $display("FAIL drop_result: valid=%b %s, required %s", a_valid, fmt(got_a()), fmt(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_unfound();
        int n;
        result_t e;
        ready = 1'b1;
        for (int k = 0; k < 15; k++) send_pixel(0, 2, 10 + k, 20);
        pulse_tab(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!a_valid && n < 300) begin @(negedge clk); n++; end
            if (k == 0) begin
                checks++;
                if (n != 1) begin errors++; $display("FAIL unfound_latency: got %0d, required 1", n); end
            end
            e = exp_q.pop_front();
            checks++;
            if (!a_valid || got_a() !== e) begin
                errors++; $display("FAIL unfound_result: valid=%b %s, required %s", a_valid, fmt(got_a()), fmt(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_div();
        int n;
        bit seen;
        result_t e;
        ready = 1'b1;
        for (int k = 0; k < 16; k++) send_pixel(0, 0, 300 + k, 600);
        pulse_tab(0, 0, 0, 0, 0, 0);
        repeat (37) @(negedge clk);
        checks++;
        if (a_count !== 20'd16) begin errors++; $display("FAIL mid_count: got %0d, required 16", a_count); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_valid, a_ch, a_x, a_y, a_count, a_found, a_sat, a_drop} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: outputs=%h, required 0",
                {a_valid, a_ch, a_x, a_y, a_count, a_found, a_sat, a_drop});
        end
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (80) begin @(negedge clk); if (a_valid) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_no_partial: valid_out seen=1, required 0"); end
        for (int k = 0; k < 16; k++) send_pixel(0, 1, $urandom_range(0, 2047), $urandom_range(0, 1023));
        for (int k = 0; k < 30; k++) send_pixel(0, 2, $urandom_range(0, 2047), $urandom_range(0, 1023));
        pulse_tab(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!a_valid && n < 300) begin @(negedge clk); n++; end
            e = exp_q.pop_front();
            checks++;
            if (!a_valid || got_a() !== e) begin
                errors++; $display("FAIL fresh_result: valid=%b %s, required %s", a_valid, fmt(got_a()), fmt(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        int n;
        result_t e;
        ready = 1'b1;
        cnt_max = 15;
        min_px = 1;
        model_clear();
        for (int k = 0; k < 20; k++) send_pixel(1, 1, 8, 3);
        pulse_tab(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!b_valid_o && n < 300) begin @(negedge clk); n++; end
            e = exp_q.pop_front();
            checks++;
            if (!b_valid_o || got_b() !== e) begin
                errors++; $display("FAIL sat_result: valid=%b %s, required %s", b_valid_o, fmt(got_b()), fmt(e));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        cnt_max = (1 << 20) - 1;
        min_px  = 16;
        model_clear();
        test_reset();
        test_basic();
        test_back_pressure();
        test_frame_drop();
        test_unfound();
        test_reset_mid_div();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/centroid_tracker.md
Name: centroid_tracker

Overview:
- Multi-channel successor to the single-blob centre-of-mass finder. Accumulates pixel coordinates per channel during a frame; channels are colour/marker classes chosen by the upstream threshold stage.
- At frame end, snapshots all accumulators into a shadow bank so accumulation of the next frame continues without a dead window.
- Divides each channel's sums by its pixel count with one shared sequential divider.
- Streams one result per channel to the stroke/cursor logic over a valid/ready handshake.

Parameters:
- X_W, 11, width of x coordinate
- Y_W, 10, width of y coordinate
- COUNT_W, 20, width of per-channel pixel counter
- NUM_CH, 4, number of tracked channels (min 1)
- CH_W, 2, width of channel index, equal to max(1, clog2(NUM_CH))
- MIN_PIXELS, 16, minimum pixel count for a valid blob

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- x_in  in  X_W  pixel x
- y_in  in  Y_W  pixel y
- ch_in  in  CH_W  channel of this pixel
- valid_in  in  1  pixel qualifies for channel ch_in
- tabulate_in  in  1  single-cycle frame-end pulse
- ready_in  in  1  downstream accepts result
- valid_out  out  1  result valid
- ch_out  out  CH_W  channel of result
- x_out  out  X_W  centroid x (floor)
- y_out  out  Y_W  centroid y (floor)
- count_out  out  COUNT_W  pixel count of channel
- found_out  out  1  count >= MIN_PIXELS
- sat_out  out  1  this channel's count or sums saturated this frame
- frame_drop_out  out  1  one-cycle pulse: tabulate arrived while busy

Behaviour:
- Reset is asynchronous and active-high. While rst_in is high, all accumulators, the shadow bank and the FSM are cleared, and every output is 0. Reset mid-computation abandons the frame; no partial result is emitted.
- Accumulators per channel:
  - sum_x width X_W+COUNT_W; sum_y width Y_W+COUNT_W; count width COUNT_W.
  - valid_in with ch_in >= NUM_CH is ignored.
  - Saturation: count stops at all-ones. The pixel that would wrap it is not added to the sums, and the channel's sat flag is set.
- Tabulate:
  - In IDLE, tabulate_in copies all accumulators and sat flags to the shadow bank and clears the live bank in the same cycle.
  - A valid_in coincident with tabulate_in belongs to the new frame; it is written as the first sample of the cleared bank.
  - Tabulate when not IDLE: the live bank is still cleared, no snapshot is taken, and frame_drop_out pulses for 1 cycle.
- FSM states: IDLE, LOAD, DIV_X, DIV_Y, EMIT.
  - IDLE -> LOAD on tabulate; channel index i = 0.
  - LOAD: if shadow count < MIN_PIXELS (this includes count 0), results are x = y = 0 and found = 0; go to EMIT with no division. Otherwise start the divider on sum_x and go to DIV_X.
  - DIV_X -> DIV_Y on divider done; start sum_y.
  - DIV_Y -> EMIT on divider done.
  - EMIT: valid_out = 1 and all result fields are held stable until ready_in.
  - On valid_out && ready_in: if i = NUM_CH-1 go to IDLE, else i++ and go to LOAD.
- Quotient is truncated to X_W / Y_W bits. The quotient is mathematically bounded by the maximum coordinate, so truncation is lossless.
- Latency: tabulate to first valid_out is 1 + 2*(DIVIDEND_W+1) cycles for a found channel, and 1 cycle for an unfound channel. DIVIDEND_W is the width of the operand being divided. Each channel costs the same again plus any back-pressure.
- Channels are emitted in ascending order, exactly NUM_CH results per accepted frame.

Decomposition:
- Package centroid_pkg:
  - localparams for sum widths
  - state enum typedef
  - result struct (ch, x, y, count, found, sat)
- Sub-module centroid_divider: restoring divider, one quotient bit per cycle.
  - Parametrised on DIVIDEND_W and DIVISOR_W.
  - Ports: start, dividend, divisor, quotient, done.
  - done asserts DIVIDEND_W+1 cycles after start.
  - Divisor 0 is never issued, because the MIN_PIXELS gate prevents it.

Test Plan:
- NUM_CH=4, MIN_PIXELS=16. Ch0 gets 16 pixels at x=100..115, y=50. Tabulate, ready_in = 1 -> ch0 result x=107, y=50, count=16, found=1; ch1..3 results found=0, x=y=0; 4 results total.
- Ch2 gets 15 pixels -> ch2 result found=0, count=15, no divider activity.
- Hold ready_in = 0 for 20 cycles during EMIT -> valid_out stays high and fields are stable; the FSM advances only on the handshake.
- Second tabulate during DIV_X -> frame_drop_out pulses once, the current frame completes with its original values, and the live bank restarts empty.
- COUNT_W=4, MIN_PIXELS=1, 20 pixels at x=8 on ch1 -> count_out=15, sat_out=1, x_out=8.
- Assert rst_in mid DIV_Y -> outputs are 0 immediately without waiting for a clock edge. A fresh frame afterwards yields correct results.
